ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side responder for the core's RAM request interface; the other end of the handshake whose requester side tracks RAM_IDLE/RAM_WAIT/RAM_DONE.
- Accepts one word-addressed read or write, waits a fixed number of cycles, performs the access on an internal word array, then pulses ready for exactly one cycle.
- Sits between the core's memory port and on-chip storage; also serves as the bench model for core verification.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two)
LATENCY, 2, cycles spent in RAM_WAIT per access; legal range 1..15
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
ren  input  1  read request; held by requester until ready
wen  input  1  write request; held by requester until ready
addr  input  32  byte address; addr[1:0] ignored
wdata  input  32  write data (word_t)
strobe  input  4  byte-lane enables for writes; bit i enables wdata[8i+7:8i]
rdata  output  32  read data; valid only while ready=1
ready  output  1  one-cycle completion pulse

Behaviour:
- One clock (clk); reset nrst asynchronous, active-low. On reset: state=RAM_IDLE, ready=0, rdata=0, counter=0, latched request cleared. Array contents are not reset.
- FSM uses ram_state_t:
  - RAM_IDLE: ready=0. At a rising edge with ren|wen=1, latch addr, wdata, strobe and op (write if wen, else read). Load counter with LATENCY and go to RAM_WAIT. Otherwise stay.
  - RAM_WAIT: decrement counter each edge. At the edge where counter==1, perform the access and go to RAM_DONE.
    - Write: update enabled byte lanes only.
    - Read: register the word into rdata.
  - RAM_DONE: ready=1 for this single cycle. Next edge: back to RAM_IDLE, ready=0. rdata holds its value until the next read completes.
- Latency: request sampled at edge E gives ready=1 in the cycle after edge E+LATENCY. Exactly one ready per sampled request.
- Turnaround: DONE always returns to IDLE. If the request is still asserted there, it is sampled as a new transaction. Minimum period is LATENCY+2 cycles per access.
- Simultaneous ren and wen: treat as a write. rdata returns the word's contents before the write (read-before-write).
- Request deassertion during RAM_WAIT: the transaction still completes from its latched values. Inputs are not re-sampled until RAM_IDLE.
- Address decode: word index = (addr - BASE_ADDR) >> 2.
  - Index >= DEPTH_WORDS: writes are dropped, reads return 32'h0, and ready is still pulsed with normal latency.
- strobe=4'b0000 on a write: no bytes change; ready still pulses.
- strobe is ignored for reads; the full word is returned. Sign and zero extension for LB/LH/LBU/LHU is the core's job.
- Reset asserted mid-transaction: state returns to RAM_IDLE immediately, no ready pulse, and a pending write is not performed.
- Counter width: 4 bits.

Decomposition:
- Shared package:
  - reuse ram_state_t and word_t;
  - add typedef logic [3:0] strobe_t;
  - add a packed ram_req_t struct {ren, wen, addr, wdata, strobe} used for the latch register.
- Sub-module ram_array:
  - synchronous single-port storage with byte write enables, read-before-write, DEPTH_WORDS parameter;
  - keeps the FSM separate from storage so the array can later map to FPGA block RAM.

Test Plan:
- Reset: hold nrst=0 with ren=1 -> ready=0, rdata=0 throughout. Release -> first ready exactly LATENCY+1 edges after the first sampling edge.
- Write/read word: wen, addr=0x10, wdata=0xDEADBEEF, strobe=4'hF, then ren at addr 0x10 -> rdata=0xDEADBEEF on the ready cycle. With LATENCY=2, ready appears the cycle after edge E+2.
- Byte lane: preload 0x11223344 at 0x20. Write wdata=0x000000AA, strobe=4'b0001 -> read gives 0x112233AA. Then strobe=4'b0100, wdata=0x00BB0000 -> read gives 0x11BB33AA.
- Out of range: ren at BASE_ADDR+4*DEPTH_WORDS -> ready pulses, rdata=0. A wen at the same address leaves every stored word unchanged.
- Early drop and back-to-back: deassert wen one cycle after sampling -> write still lands and ready pulses once. Hold ren across two transactions -> two ready pulses spaced LATENCY+2 cycles apart.
- Reset mid-op: wen to 0x30 (prior 0x0), assert nrst=0 during RAM_WAIT -> no ready. Later read of 0x30 returns 0x0. Simultaneous ren+wen with wdata=0x5 at a word holding 0x7 -> rdata=0x7, and a following read returns 0x5.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared types for the RAM request/response handshake.
package ram_responder_pkg;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;
    typedef enum logic [1:0] {RAM_IDLE, RAM_WAIT, RAM_DONE} ram_state_t;
    typedef struct packed {
        logic    ren;
        logic    wen;
        word_t   addr;
        word_t   wdata;
        strobe_t strobe;
    } ram_req_t;
endpackage

// File: rtl/ram_responder_array.sv
// ram_array: synchronous single-port word storage with byte write enables.
// The read register captures the word before any write in the same cycle.
module ram_array
    import ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  word_t         wdata_i,
    input  strobe_t       strobe_i,
    output word_t         rdata_o
);
    word_t mem_q [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_o <= mem_q[idx_i];
            for (int i = 0; i < 4; i++)
                if (we_i && strobe_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: fixed-latency memory responder; latches one request, waits
// LATENCY cycles, performs the access, then pulses ready for one cycle.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter word_t BASE_ADDR   = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    nrst,
    input  logic    ren,
    input  logic    wen,
    input  word_t   addr,
    input  word_t   wdata,
    input  strobe_t strobe,
    output word_t   rdata,
    output logic    ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    ram_state_t  state_q;
    ram_req_t    req_q;
    logic [3:0]  cnt_q;
    word_t       rdata_q;
    logic        ready_q;
    logic [29:0] word_off;
    logic        in_range;
    logic        fire;
    word_t       arr_rdata;
    word_t       done_rdata;
    assign word_off   = 30'((req_q.addr - BASE_ADDR) >> 2);
    assign in_range   = word_off < 30'(DEPTH_WORDS);
    assign fire       = state_q == RAM_WAIT && cnt_q == 4'd1;
    assign done_rdata = in_range ? arr_rdata : '0;
    assign ready      = ready_q;
    // The array's read register is live during DONE; rdata_q keeps it afterwards.
    assign rdata      = (state_q == RAM_DONE && req_q.ren) ? done_rdata : rdata_q;
    ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk      (clk),
        .en_i     (fire && in_range),
        .we_i     (req_q.wen),
        .idx_i    (word_off[AW-1:0]),
        .wdata_i  (req_q.wdata),
        .strobe_i (req_q.strobe),
        .rdata_o  (arr_rdata)
    );
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= RAM_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RAM_IDLE: if (ren || wen) begin
                    req_q   <= '{ren: ren, wen: wen, addr: addr, wdata: wdata, strobe: strobe};
                    cnt_q   <= 4'(LATENCY);
                    state_q <= RAM_WAIT;
                end
                RAM_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RAM_DONE;
                        ready_q <= 1'b1;
                    end
                end
                RAM_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= RAM_IDLE;
                    if (req_q.ren) rdata_q <= done_rdata;
                end
                default: state_q <= RAM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed scoreboard bench; the driver queues expected
// ready cycle and read data, a negedge monitor pops on every ready pulse.
module tb_ram_responder;
    import ram_responder_pkg::*;
    localparam int LAT = 2;
    typedef struct {
        int    cyc;
        logic  chk;
        word_t rd;
    } exp_t;
    logic    clk = 1'b0;
    logic    nrst;
    logic    ren, wen;
    word_t   addr, wdata, rdata;
    strobe_t strobe;
    logic    ready;
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_bad = 0;
    exp_t    q[$];
    exp_t    e;

    ram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .ren    (ren),
        .wen    (wen),
        .addr   (addr),
        .wdata  (wdata),
        .strobe (strobe),
        .rdata  (rdata),
        .ready  (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input word_t act, input word_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_ready: pulse at cycle %0d, required none", cyc);
            end else begin
                e = q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk) check("rdata", rdata, e.rd);
            end
        end
    end

    task automatic wait_ready(input int n, input logic hold);
        int got = 0;
        for (int k = 0; k < 40 && got < n; k++) begin
            @(negedge clk);
            if (!hold) begin
                ren = 1'b0;
                wen = 1'b0;
            end
            if (ready) got++;
        end
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d ready pulses, required %0d", got, n);
        end
    endtask

    task automatic go(input logic r, input logic w, input word_t a, input word_t d,
                      input strobe_t s, input logic hold, input logic chk, input word_t rd);
        @(negedge clk);
        ren = r;
        wen = w;
        addr = a;
        wdata = d;
        strobe = s;
        q.push_back('{cyc: cyc + LAT + 1, chk: chk, rd: rd});
        wait_ready(1, hold);
        ren = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        ren = 1'b1;
        wen = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        strobe = 4'h0;
        repeat (4) begin
            @(negedge clk);
            check("reset_ready", 32'(ready), 32'h0);
            check("reset_rdata", rdata, 32'h0);
        end
        nrst = 1'b1;
        q.push_back('{cyc: cyc + LAT + 1, chk: 1'b0, rd: 32'h0});
        wait_ready(1, 1'b1);
        ren = 1'b0;
        go(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
        go(1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 32'hDEAD_BEEF);
        go(0, 1, 32'h20, 32'h1122_3344, 4'hF, 1, 0, 0);
        go(0, 1, 32'h20, 32'h0000_00AA, 4'b0001, 1, 0, 0);
        go(1, 0, 32'h20, 32'h0, 4'h0, 1, 1, 32'h1122_33AA);
        go(0, 1, 32'h20, 32'h00BB_0000, 4'b0100, 1, 0, 0);
        go(1, 0, 32'h20, 32'h0, 4'h0, 1, 1, 32'h11BB_33AA);
        go(0, 1, 32'h0, 32'hA5A5_A5A5, 4'hF, 1, 0, 0);
        go(1, 0, 32'h1000, 32'h0, 4'h0, 1, 1, 32'h0);
        go(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        go(1, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hA5A5_A5A5);
        go(1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 32'hDEAD_BEEF);
        go(1, 0, 32'h20, 32'h0, 4'h0, 1, 1, 32'h11BB_33AA);
        go(0, 1, 32'h10, 32'h0, 4'h0, 1, 0, 0);
        go(1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 32'hDEAD_BEEF);
        go(0, 1, 32'h40, 32'h1234_5678, 4'hF, 0, 0, 0);
        go(1, 0, 32'h40, 32'h0, 4'h0, 1, 1, 32'h1234_5678);
        @(negedge clk);
        ren = 1'b1;
        addr = 32'h40;
        q.push_back('{cyc: cyc + LAT + 1, chk: 1'b1, rd: 32'h1234_5678});
        q.push_back('{cyc: cyc + 2 * LAT + 3, chk: 1'b1, rd: 32'h1234_5678});
        wait_ready(2, 1'b1);
        ren = 1'b0;
        go(0, 1, 32'h30, 32'h0, 4'hF, 1, 0, 0);
        @(negedge clk);
        wen = 1'b1;
        addr = 32'h30;
        wdata = 32'hCAFE_F00D;
        strobe = 4'hF;
        @(negedge clk);
        nrst = 1'b0;
        wen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midreset_ready", 32'(ready), 32'h0);
            check("midreset_rdata", rdata, 32'h0);
        end
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        go(1, 0, 32'h30, 32'h0, 4'h0, 1, 1, 32'h0);
        go(0, 1, 32'h50, 32'h7, 4'hF, 1, 0, 0);
        go(1, 1, 32'h50, 32'h5, 4'hF, 1, 1, 32'h7);
        go(1, 0, 32'h50, 32'h0, 4'h0, 1, 1, 32'h5);
        repeat (10) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
